bus_requester: RTL and testbench
================================

Name: bus_requester

Overview:
- Per-processor bus front end that sits directly upstream of the common-bus arbiter; one instance per core, four in the system.
- Buffers miss, upgrade and write-back commands from the cache controller in a 2-entry queue.
- Drives the core's Com_Bus_Req_proc bit and waits for the matching Com_Bus_Gnt_proc bit.
- Issues the command on the bus, waits for completion, and returns data or an error to the cache controller.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 16, maximum cycles in XFER waiting for completion before an error is returned.
- MAX_RETRY, 3, number of re-arbitrations allowed after grant loss before an error is returned.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  command from the cache controller is valid.
- cpu_req_ready  out  1  queue can accept a command (queue not full).
- cpu_req_cmd  in  2  0=BusRd, 1=BusRdX, 2=BusUpgr, 3=WriteBack.
- cpu_req_addr  in  ADDR_W  line address.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_data  out  DATA_W  data returned by the bus; holds its last value when cpu_resp_valid is low.
- cpu_resp_err  out  1  qualifies cpu_resp_valid; 1 = timeout or retry exhaustion.
- Com_Bus_Req_proc  out  1  bus request to the arbiter; registered.
- Com_Bus_Gnt_proc  in  1  grant from the arbiter; combinational on the arbiter side.
- bus_cmd_valid  out  1  one-cycle command strobe.
- bus_cmd  out  2  command for the head queue entry.
- bus_addr  out  ADDR_W  address for the head queue entry.
- bus_data_valid  in  1  completion/ack from the responder; carries data for reads.
- bus_data_in  in  DATA_W  response data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; queue is emptied.
  - Retry and timeout counters clear to 0.
  - All outputs go to 0, except cpu_req_ready=1.
- Queue:
  - 2 entries, each holding {cmd, addr}; write/read pointers wrap mod 2; 2-bit count.
  - A push occurs when cpu_req_valid && cpu_req_ready.
  - A pop occurs only on the cycle the FSM leaves RESP.
  - cpu_req_ready = (count != 2), computed combinationally from the count register.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
- FSM states: IDLE, REQ, XFER, RESP.
  - IDLE: Com_Bus_Req_proc=0. If count != 0, go to REQ.
  - REQ:
    - Com_Bus_Req_proc=1, registered, so it is first visible the cycle after entering REQ.
    - When Com_Bus_Gnt_proc=1 is sampled, go to XFER and clear the timeout counter.
    - No time limit in REQ; lower-index cores may starve this core.
  - XFER:
    - Com_Bus_Req_proc stays 1.
    - bus_cmd_valid=1 on the first XFER cycle only.
    - bus_cmd and bus_addr hold the head entry for the whole of XFER.
    - The timeout counter increments each cycle.
    - Priority of exits when several conditions hold in the same cycle:
      - (a) bus_data_valid=1: capture bus_data_in, set err=0, go to RESP. Completion wins over grant loss and timeout in the same cycle.
      - (b) Com_Bus_Gnt_proc=0: if retry count < MAX_RETRY, increment it and go to REQ; otherwise set err=1 and go to RESP.
      - (c) timeout counter == TIMEOUT-1: set err=1 and go to RESP.
  - RESP:
    - One cycle only, then IDLE.
    - cpu_resp_valid=1, with cpu_resp_data and cpu_resp_err from the captured values.
    - Com_Bus_Req_proc=0 on this cycle. This guarantees at least one low cycle between transactions so the arbiter can rotate.
    - Pop the head entry and clear the retry counter.
- Latency:
  - Push into an empty queue → Com_Bus_Req_proc high 2 cycles later.
  - Grant sampled → bus_cmd_valid on the next cycle.
  - bus_data_valid → cpu_resp_valid on the next cycle.
- Write-backs: bus_data_valid is treated as the ack; cpu_resp_data is don't-care and is captured anyway.
- Reset mid-transaction: everything is abandoned; Com_Bus_Req_proc drops asynchronously; no response is produced.

Test Plan:
- Single BusRd, addr 0x0000_1040:
  - Stimulus: grant 1 cycle after the request rises; bus_data_valid with 0xDEADBEEF 3 cycles after bus_cmd_valid.
  - Required response: bus_cmd=0 and bus_addr=0x1040 for one strobe; cpu_resp_valid pulse with data 0xDEADBEEF and err=0; Com_Bus_Req_proc low in the RESP cycle.
- Queue full:
  - Stimulus: push 3 commands back-to-back with no grant.
  - Required response: cpu_req_ready goes 0 after the 2nd push and the 3rd is not accepted. Granting both gives 2 responses in push order, and ready returns to 1 after the first RESP.
- Timeout (TIMEOUT=16):
  - Stimulus: grant held, bus_data_valid never asserted.
  - Required response: cpu_resp_err=1 exactly 16 cycles after entering XFER.
- Grant loss (MAX_RETRY=3):
  - Stimulus: grant dropped mid-XFER 4 times.
  - Required response: 3 returns to REQ, each followed by a new bus_cmd_valid; on the 4th loss, a response with err=1.
- Simultaneous events:
  - Stimulus: bus_data_valid and grant deassertion in the same cycle.
  - Required response: normal completion with err=0.
  - Stimulus: push while the FSM leaves RESP with count=2.
  - Required response: the push is rejected because ready=0; count goes to 1.
- Async reset:
  - Stimulus: assert rst=0 mid-XFER, between clock edges.
  - Required response: Com_Bus_Req_proc and bus_cmd_valid go 0 immediately; no cpu_resp_valid; ready=1 after reset is released.

Source files
------------

// File: rtl/bus_requester.sv
// Per-core bus front end: queues cache commands, requests the common bus,
// issues the head command and returns data or an error to the cache.
//
// Ports:
//   clk, rst                   clock, async active-low reset
//   cpu_req_valid/ready        command push handshake from the cache
//   cpu_req_cmd/addr           0=BusRd 1=BusRdX 2=BusUpgr 3=WriteBack, line address
//   cpu_resp_valid/data/err    one-cycle completion pulse to the cache
//   Com_Bus_Req_proc           registered request to the arbiter
//   Com_Bus_Gnt_proc           grant from the arbiter
//   bus_cmd_valid/cmd/addr     one-cycle command strobe and held command
//   bus_data_valid/data_in     completion ack and response data
module bus_requester #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic [1:0]        cpu_req_cmd,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   output logic              cpu_resp_valid,
   output logic [DATA_W-1:0] cpu_resp_data,
   output logic              cpu_resp_err,
   output logic              Com_Bus_Req_proc,
   input  logic              Com_Bus_Gnt_proc,
   output logic              bus_cmd_valid,
   output logic [1:0]        bus_cmd,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_data_valid,
   input  logic [DATA_W-1:0] bus_data_in
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int RW = $clog2(MAX_RETRY + 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_RESP
   } state_t;

   state_t            r_state;
   logic [1:0]        r_q_cmd  [2];
   logic [ADDR_W-1:0] r_q_addr [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic [TW-1:0]     r_tmo;
   logic [RW-1:0]     r_retry;

   logic w_push;
   logic w_pop;

   assign cpu_req_ready = (r_count != 2'd2);
   assign w_push        = cpu_req_valid && cpu_req_ready;
   // The head entry is retired on the edge that leaves RESP.
   assign w_pop         = (r_state == S_RESP);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_cmd[r_wptr]  <= cpu_req_cmd;
         r_q_addr[r_wptr] <= cpu_req_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= S_IDLE;
         r_tmo            <= '0;
         r_retry          <= '0;
         Com_Bus_Req_proc <= 1'b0;
         bus_cmd_valid    <= 1'b0;
         bus_cmd          <= '0;
         bus_addr         <= '0;
         cpu_resp_valid   <= 1'b0;
         cpu_resp_data    <= '0;
         cpu_resp_err     <= 1'b0;
      end else begin
         bus_cmd_valid  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               Com_Bus_Req_proc <= 1'b0;
               if (r_count != 2'd0) r_state <= S_REQ;
            end
            S_REQ: begin
               Com_Bus_Req_proc <= 1'b1;
               if (Com_Bus_Gnt_proc) begin
                  r_state       <= S_XFER;
                  r_tmo         <= '0;
                  bus_cmd_valid <= 1'b1;
                  bus_cmd       <= r_q_cmd[r_rptr];
                  bus_addr      <= r_q_addr[r_rptr];
               end
            end
            S_XFER: begin
               r_tmo <= r_tmo + TW'(1);
               // Completion beats grant loss, which beats timeout.
               if (bus_data_valid) begin
                  cpu_resp_data    <= bus_data_in;
                  cpu_resp_err     <= 1'b0;
                  cpu_resp_valid   <= 1'b1;
                  Com_Bus_Req_proc <= 1'b0;
                  r_state          <= S_RESP;
               end else if (!Com_Bus_Gnt_proc) begin
                  if (r_retry < RW'(MAX_RETRY)) begin
                     r_retry <= r_retry + RW'(1);
                     r_state <= S_REQ;
                  end else begin
                     cpu_resp_err     <= 1'b1;
                     cpu_resp_valid   <= 1'b1;
                     Com_Bus_Req_proc <= 1'b0;
                     r_state          <= S_RESP;
                  end
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  cpu_resp_err     <= 1'b1;
                  cpu_resp_valid   <= 1'b1;
                  Com_Bus_Req_proc <= 1'b0;
                  r_state          <= S_RESP;
               end
            end
            S_RESP: begin
               Com_Bus_Req_proc <= 1'b0;
               r_retry          <= '0;
               r_state          <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_requester.sv
// Randomized bench for bus_requester: arbiter/responder model drives the bus,
// expected responses are queued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_bus_requester;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req_valid = 1'b0;
   logic          cpu_req_ready;
   logic [1:0]    cpu_req_cmd = '0;
   logic [AW-1:0] cpu_req_addr = '0;
   logic          cpu_resp_valid;
   logic [DW-1:0] cpu_resp_data;
   logic          cpu_resp_err;
   logic          Com_Bus_Req_proc;
   logic          Com_Bus_Gnt_proc = 1'b0;
   logic          bus_cmd_valid;
   logic [1:0]    bus_cmd;
   logic [AW-1:0] bus_addr;
   logic          bus_data_valid = 1'b0;
   logic [DW-1:0] bus_data_in = '0;

   always #5 clk = ~clk;

   bus_requester #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .MAX_RETRY(3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_req_valid    (cpu_req_valid),
      .cpu_req_ready    (cpu_req_ready),
      .cpu_req_cmd      (cpu_req_cmd),
      .cpu_req_addr     (cpu_req_addr),
      .cpu_resp_valid   (cpu_resp_valid),
      .cpu_resp_data    (cpu_resp_data),
      .cpu_resp_err     (cpu_resp_err),
      .Com_Bus_Req_proc (Com_Bus_Req_proc),
      .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
      .bus_cmd_valid    (bus_cmd_valid),
      .bus_cmd          (bus_cmd),
      .bus_addr         (bus_addr),
      .bus_data_valid   (bus_data_valid),
      .bus_data_in      (bus_data_in)
   );

   typedef struct packed {
      logic          err;
      logic [DW-1:0] data;
   } resp_t;

   typedef struct packed {
      logic [1:0]    cmd;
      logic [AW-1:0] addr;
   } req_t;

   localparam int E_WREQ = 0;
   localparam int E_GDLY = 1;
   localparam int E_GNT  = 2;
   localparam int E_XF   = 3;
   localparam int E_DONE = 4;

   int n_chk = 0;
   int n_fail = 0;

   resp_t expq[$];
   req_t  mq[$];
   logic [DW-1:0] last_data;
   int retry;
   int est, gdly, age, act_age, kind, exp_age;
   bit drop_too;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic flag(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Response monitor: pops the scoreboard whenever the DUT responds.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && cpu_resp_valid) begin
            if (expq.size() == 0) begin
               flag("unexpected_resp");
            end else begin
               resp_t e;
               e = expq.pop_front();
               chk("resp_err", cpu_resp_err, e.err);
               chk("resp_data", cpu_resp_data, e.data);
               chk("req_low_in_resp", Com_Bus_Req_proc, 1'b0);
            end
         end
      end
   end

   task automatic do_action();
      resp_t r;
      unique case (kind)
         0: begin
            bus_data_valid = 1'b1;
            bus_data_in    = $urandom;
            if (drop_too) Com_Bus_Gnt_proc = 1'b0;
            r.err = 1'b0;
            r.data = bus_data_in;
            expq.push_back(r);
            last_data = bus_data_in;
            retry = 0;
            exp_age = age + 1;
            est = E_DONE;
         end
         1: begin
            Com_Bus_Gnt_proc = 1'b0;
            if (retry < 3) begin
               retry++;
               est = E_WREQ;
            end else begin
               r.err = 1'b1;
               r.data = last_data;
               expq.push_back(r);
               retry = 0;
               exp_age = age + 1;
               est = E_DONE;
            end
         end
         default: begin
            r.err = 1'b1;
            r.data = last_data;
            expq.push_back(r);
            retry = 0;
            exp_age = age + 1;
            est = E_DONE;
         end
      endcase
   endtask

   task automatic env_cycle(input bit allow_push, input bit force_push,
                            input bit hold);
      bit   pop;
      bit   push;
      req_t q;
      int   r;
      @(negedge clk);
      chk("ready", cpu_req_ready, mq.size() != 2);
      pop  = cpu_resp_valid;
      push = 1'b0;
      if (force_push || (allow_push && $urandom_range(0, 1) == 1)) begin
         cpu_req_valid = 1'b1;
         cpu_req_cmd   = 2'($urandom_range(0, 3));
         cpu_req_addr  = $urandom;
         push = (mq.size() != 2);
      end else begin
         cpu_req_valid = 1'b0;
      end
      bus_data_valid = 1'b0;
      if (bus_cmd_valid && est != E_GNT) flag("stray_cmd_valid");
      case (est)
         E_WREQ: begin
            Com_Bus_Gnt_proc = 1'b0;
            if (Com_Bus_Req_proc) begin
               gdly = $urandom_range(0, 3);
               est = E_GDLY;
            end
         end
         E_GDLY: begin
            if (gdly == 0) begin
               Com_Bus_Gnt_proc = 1'b1;
               est = E_GNT;
            end else begin
               gdly--;
            end
         end
         E_GNT: begin
            if (bus_cmd_valid) begin
               if (mq.size() == 0) begin
                  flag("cmd_with_empty_queue");
               end else begin
                  chk("bus_cmd", bus_cmd, mq[0].cmd);
                  chk("bus_addr", bus_addr, mq[0].addr);
               end
               est = E_XF;
               age = 1;
               r = $urandom_range(0, 99);
               kind = (r < 55) ? 0 : (r < 85) ? 1 : 2;
               act_age = (kind == 2) ? 16 : $urandom_range(1, 16);
               drop_too = ($urandom_range(0, 3) == 0);
               if (hold) begin
                  kind = 3;
                  act_age = 0;
               end
            end else begin
               flag("cmd_valid_latency");
            end
         end
         E_XF: begin
            age++;
         end
         E_DONE: begin
            age++;
            if (cpu_resp_valid) begin
               chk("resp_latency", age, exp_age);
               Com_Bus_Gnt_proc = 1'b0;
               est = E_WREQ;
            end else if (age > exp_age + 3) begin
               flag("resp_missing");
               Com_Bus_Gnt_proc = 1'b0;
               est = E_WREQ;
            end
         end
         default: est = E_WREQ;
      endcase
      if (est == E_XF && age == act_age) do_action();
      if (push) begin
         q.cmd  = cpu_req_cmd;
         q.addr = cpu_req_addr;
         mq.push_back(q);
      end
      if (pop && mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic model_reset();
      mq.delete();
      expq.delete();
      last_data = '0;
      retry = 0;
      est = E_WREQ;
      age = 0;
      act_age = 0;
      kind = 0;
      exp_age = 0;
      cpu_req_valid = 1'b0;
      Com_Bus_Gnt_proc = 1'b0;
      bus_data_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (mq.size() == 0 && est == E_WREQ) break;
         env_cycle(1'b0, 1'b0, 1'b0);
      end
      chk("drain_queue", mq.size(), 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", expq.size(), 0);
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst_ready", cpu_req_ready, 1'b1);
      chk("rst_req", Com_Bus_Req_proc, 1'b0);
      chk("rst_cmd_valid", bus_cmd_valid, 1'b0);
      chk("rst_resp_valid", cpu_resp_valid, 1'b0);
      chk("rst_resp_err", cpu_resp_err, 1'b0);
      chk("rst_resp_data", cpu_resp_data, 0);
      chk("rst_bus_addr", bus_addr, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      repeat (3000) env_cycle(1'b1, 1'b0, 1'b0);
      drain();

      env_cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 50; i++) begin
         if (est == E_XF) break;
         env_cycle(1'b0, 1'b0, 1'b1);
      end
      chk("reached_xfer", est, E_XF);
      chk("cmd_valid_before_rst", bus_cmd_valid, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("async_req_drop", Com_Bus_Req_proc, 1'b0);
      chk("async_cmd_drop", bus_cmd_valid, 1'b0);
      chk("async_resp", cpu_resp_valid, 1'b0);
      chk("async_ready", cpu_req_ready, 1'b1);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_resp", cpu_resp_valid, 1'b0);
         chk("post_rst_req", Com_Bus_Req_proc, 1'b0);
         chk("post_rst_ready", cpu_req_ready, 1'b1);
      end

      repeat (400) env_cycle(1'b1, 1'b0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
